zap_ram_multi_rd: RTL

//  Pipelined, write-forwarding register-file/cache RAM: one byte-maskable write port, RD_PORTS read ports.

---
 rtl/zap_ram_multi_rd.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/zap_ram_multi_rd.sv
// zap_ram_multi_rd: pipelined multi-read-port RAM with byte-masked,
// write-first forwarding into every in-flight read.
//
// Ports:
//   i_clk, i_reset_n (sync, active low), i_clken (global enable)
//   i_wr_en / i_wr_be / i_wr_addr / i_wr_data : single write port
//   i_rd_en[p], i_rd_addr[p*AW +: AW]         : per-port read request
//   o_rd_data[p*WIDTH +: WIDTH], o_rd_valid[p]: registered read result
module zap_ram_multi_rd #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int RD_PORTS     = 2,
    parameter int READ_LATENCY = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BW = WIDTH / 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_clken,
    input  logic                      i_wr_en,
    input  logic [BW-1:0]             i_wr_be,
    input  logic [AW-1:0]             i_wr_addr,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic [RD_PORTS-1:0]       i_rd_en,
    input  logic [RD_PORTS*AW-1:0]    i_rd_addr,
    output logic [RD_PORTS*WIDTH-1:0] o_rd_data,
    output logic [RD_PORTS-1:0]       o_rd_valid
);

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("zap_ram_multi_rd: WIDTH must be a multiple of 8");
    end

    localparam bit POW2 = (DEPTH == (1 << AW));

    logic [WIDTH-1:0]    mem [DEPTH];
    logic                wr_ok;
    logic [RD_PORTS-1:0] rd_ok;
    logic [WIDTH-1:0]    s1_next [RD_PORTS];

    function automatic logic [WIDTH-1:0] merge(
        input logic [WIDTH-1:0] base,
        input logic [WIDTH-1:0] wdata,
        input logic [BW-1:0]    be
    );
        logic [WIDTH-1:0] r;
        r = base;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) begin
                r[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return r;
    endfunction

    // Address range qualification; every address is legal when
    // DEPTH fills the whole address space.
    if (POW2) begin : g_full
        assign wr_ok = i_wr_en;
        assign rd_ok = '1;
    end else begin : g_part
        localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

        assign wr_ok = i_wr_en && ({1'b0, i_wr_addr} < DEPTH_L);

        always_comb begin
            rd_ok = '0;
            for (int p = 0; p < RD_PORTS; p++) begin
                rd_ok[p] = {1'b0, i_rd_addr[p*AW +: AW]} < DEPTH_L;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n && i_clken && wr_ok) begin
            for (int b = 0; b < BW; b++) begin
                if (i_wr_be[b]) begin
                    mem[i_wr_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Stage-1 data: array word with the same-cycle write merged in
    // (write-first). Out-of-range reads yield zero.
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            s1_next[p] = '0;
            if (rd_ok[p]) begin
                if (wr_ok && (i_wr_addr == i_rd_addr[p*AW +: AW])) begin
                    s1_next[p] = merge(mem[i_rd_addr[p*AW +: AW]],
                                       i_wr_data, i_wr_be);
                end else begin
                    s1_next[p] = mem[i_rd_addr[p*AW +: AW]];
                end
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
                o_rd_valid <= '0;
                o_rd_data  <= '0;
            end else if (i_clken) begin
                o_rd_valid <= i_rd_en;
                for (int p = 0; p < RD_PORTS; p++) begin
                    if (i_rd_en[p]) begin
                        o_rd_data[p*WIDTH +: WIDTH] <= s1_next[p];
                    end
                end
            end
        end
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic [RD_PORTS-1:0]    s1_valid;
        logic [RD_PORTS*AW-1:0] s1_addr;
        logic [WIDTH-1:0]       s1_data [RD_PORTS];
        logic [WIDTH-1:0]       s2_next [RD_PORTS];

        // A write landing while the read is in stage 1 overrides
        // its enabled bytes. wr_ok already excludes out-of-range
        // addresses, so an out-of-range read keeps its zero data.
        always_comb begin
            for (int p = 0; p < RD_PORTS; p++) begin
                s2_next[p] = s1_data[p];
                if (wr_ok && (i_wr_addr == s1_addr[p*AW +: AW])) begin
                    s2_next[p] = merge(s1_data[p], i_wr_data, i_wr_be);
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
                s1_valid   <= '0;
                s1_addr    <= '0;
                o_rd_valid <= '0;
                o_rd_data  <= '0;
                for (int p = 0; p < RD_PORTS; p++) begin
                    s1_data[p] <= '0;
                end
            end else if (i_clken) begin
                s1_valid   <= i_rd_en;
                o_rd_valid <= s1_valid;
                for (int p = 0; p < RD_PORTS; p++) begin
                    if (i_rd_en[p]) begin
                        s1_addr[p*AW +: AW] <= i_rd_addr[p*AW +: AW];
                        s1_data[p]          <= s1_next[p];
                    end
                    if (s1_valid[p]) begin
                        o_rd_data[p*WIDTH +: WIDTH] <= s2_next[p];
                    end
                end
            end
        end
    end else begin : g_bad_lat
        $error("zap_ram_multi_rd: READ_LATENCY must be 1 or 2");
    end

endmodule
